counter_updown_mod: RTL

COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

---
 rtl/counter_pkg.sv | 36 +++
 rtl/counter_prescale.sv | 41 ++++
 rtl/counter_updown_mod.sv | 111 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared defaults and per-cycle command encoding for the
//               up/down counter and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX      = 255;
    localparam int DEF_PRESCALE = 1;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_CLR  = 2'd0;
    localparam cmd_t CMD_LOAD = 2'd1;
    localparam cmd_t CMD_STEP = 2'd2;
    localparam cmd_t CMD_HOLD = 2'd3;

    // Resolves the clr > load > step > hold priority into one command.
    function automatic cmd_t sel_cmd(input logic clr, input logic load, input logic step);
        cmd_t cmd;
        if (clr)
            cmd = CMD_CLR;
        else if (load)
            cmd = CMD_LOAD;
        else if (step)
            cmd = CMD_STEP;
        else
            cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_prescale.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescale
// Description : Counts enabled cycles 0..PRESCALE-1 and pulses tick on the last.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescale
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] c_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;

    // With PRESCALE=1 r_cnt stays at zero and tick simply follows en.
    assign tick = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_mod
// Description : Prescaled up/down counter with clear, clamped load and
//               terminal-count flag. COUNTER_SAT_EN selects saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX      = DEF_MAX,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic             w_tick;
    cmd_t             w_cmd;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    // clr and load both restart the prescaler so the next step is a full period away.
    counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (w_tick)
    );

    always_comb begin
        w_cmd       = sel_cmd(clr, load, w_tick);
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        case (w_cmd)
            CMD_CLR: begin
                w_count_nxt = c_ZERO;
            end
            CMD_LOAD: begin
                w_count_nxt = (load_val > c_MAX) ? c_MAX : load_val;
            end
            CMD_STEP: begin
                if (up) begin
                    if (r_count == c_MAX) begin
`ifdef COUNTER_SAT_EN
                        w_count_nxt = c_MAX;
`else
                        w_count_nxt = c_ZERO;
                        w_tc_nxt    = 1'b1;
`endif
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end else begin
                    if (r_count == c_ZERO) begin
`ifdef COUNTER_SAT_EN
                        w_count_nxt = c_ZERO;
`else
                        w_count_nxt = c_MAX;
                        w_tc_nxt    = 1'b1;
`endif
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
            end
            CMD_HOLD: begin
                w_count_nxt = r_count;
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
`ifdef COUNTER_SAT_EN
        // In saturating mode tc marks sitting at the limit in the current direction.
        if ((w_cmd == CMD_STEP) || (w_cmd == CMD_HOLD))
            w_tc_nxt = en && (up ? (w_count_nxt == c_MAX) : (w_count_nxt == c_ZERO));
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule
`default_nettype wire
